// File: rtl/rpn_exec.sv
//------------------------------------------------------------------------------
// rpn_exec: RPN operand-stack sequencer driving the calculator ALU.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AC_N
`define AC_N  3
`define AC_AD 3'd0
`define AC_SB 3'd1
`define AC_MU 3'd2
`define AC_DI 3'd3
`endif

module rpn_exec #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_op,
    input  logic [N-1:0]      in_data,
    input  logic [`AC_N-1:0]  in_op,
    input  logic              clear,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [`AC_N-1:0]  alu_cmd,
    input  logic [N-1:0]      alu_c,
    output logic [N-1:0]      top,
    output logic              top_valid,
    output logic [AW:0]       depth,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0]  c_err_under = 2'd1;
    localparam logic [1:0]  c_err_over  = 2'd2;
    localparam logic [1:0]  c_err_arith = 2'd3;
    localparam logic [AW:0] c_full      = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_two       = (AW+1)'(2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_sp;
    logic [N-1:0]      r_stack [DEPTH];
    logic [N-1:0]      r_alu_a;
    logic [N-1:0]      r_alu_b;
    logic [`AC_N-1:0]  r_alu_cmd;
    logic [N-1:0]      r_result;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_push;
    logic              w_wb;
    logic              w_load;
    logic              w_err_set;
    logic [1:0]        w_err_code;
    logic              w_op_legal;
    logic [AW-1:0]     w_top_idx;
    logic [AW-1:0]     w_sec_idx;

    // Indices wrap naturally: sp==DEPTH has zero low bits, so sp-1 lands on DEPTH-1.
    assign w_top_idx  = r_sp[AW-1:0] - 1'b1;
    assign w_sec_idx  = r_sp[AW-1:0] - 2'd2;
    assign w_op_legal = (in_op == `AC_AD) || (in_op == `AC_SB) ||
                        (in_op == `AC_MU) || (in_op == `AC_DI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_wb        = 1'b0;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = r_err_code;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!in_is_op) begin
                            if (r_sp == c_full) begin
                                w_err_set  = 1'b1;
                                w_err_code = c_err_over;
                            end else begin
                                w_push = 1'b1;
                            end
                        end else if (r_sp < c_two) begin
                            w_err_set  = 1'b1;
                            w_err_code = c_err_under;
                        end else if (!w_op_legal) begin
                            w_err_set  = 1'b1;
                            w_err_code = c_err_arith;
                        end else if ((in_op == `AC_DI) && (r_stack[w_top_idx] == '0)) begin
                            w_err_set  = 1'b1;
                            w_err_code = c_err_arith;
                        end else begin
                            w_load = 1'b1;
                        end
                        if (w_err_set)   w_state_nxt = S_ERR;
                        else if (w_load) w_state_nxt = S_EXEC;
                    end
                end
                S_EXEC:  w_state_nxt = S_WB;
                S_WB: begin
                    w_wb        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_cmd  <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_done <= (w_state_nxt == S_WB);
            if (clear) begin
                r_sp       <= '0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
            end else begin
                if (w_push) r_sp <= r_sp + 1'b1;
                if (w_wb)   r_sp <= r_sp - 1'b1;
                if (w_err_set) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code;
                end
            end
            if (w_load) begin
                r_alu_a   <= r_stack[w_sec_idx];
                r_alu_b   <= r_stack[w_top_idx];
                r_alu_cmd <= in_op;
            end
            if (!clear && (r_state == S_EXEC)) r_result <= alu_c;
        end
    end

    // Stack storage carries no reset; its contents are meaningless while sp is 0.
    always_ff @(posedge clk) begin
        if (w_push)    r_stack[r_sp[AW-1:0]] <= in_data;
        else if (w_wb) r_stack[w_sec_idx]    <= r_result;
    end

    assign in_ready  = (r_state == S_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cmd   = r_alu_cmd;
    assign top_valid = (r_sp != '0);
    assign top       = top_valid ? r_stack[w_top_idx] : '0;
    assign depth     = r_sp;
    assign done      = r_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: doc/rpn_exec.md
Name: rpn_exec

Overview:
- Operand-stack sequencer that sits directly upstream of the calculator ALU.
- Accepts a token stream of numbers and operators, keeps operands on an internal LIFO stack, and drives the ALU's A/B/cmd inputs from the top two entries.
- Captures the ALU result and pushes it back onto the stack.
- Exposes the stack top for display and flags underflow, overflow and arithmetic errors.

Parameters:
- N, 16, operand/result width; matches the ALU width.
- DEPTH, 8, stack entries (power of two, minimum 2).
- AW, 3, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  token present.
- in_ready  out  1  block can accept a token this cycle.
- in_is_op  in  1  1 = operator token, 0 = number token.
- in_data  in  N  signed number (number tokens only).
- in_op  in  `AC_N  operator, encoded as the ALU_INTERFACE.v command codes (`AC_AD/`AC_SB/`AC_MU/`AC_DI).
- clear  in  1  synchronous flush of stack and error.
- alu_a  out  N  registered ALU operand A (second-from-top).
- alu_b  out  N  registered ALU operand B (top).
- alu_cmd  out  `AC_N  registered ALU command.
- alu_c  in  N  combinational ALU result.
- top  out  N  stack[sp-1] when depth>0, else 0.
- top_valid  out  1  depth>0.
- depth  out  AW+1  number of occupied entries, 0..DEPTH.
- done  out  1  one-cycle pulse when an operator result is written back.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 arithmetic (divide by zero or illegal op).

Behaviour:
- Reset (rst_n low, asynchronous), all of the following:
  - state IDLE, sp=0.
  - alu_a, alu_b, alu_cmd, the result register, done, err and err_code all 0.
  - Stack contents don't-care; top=0.
- Reset mid-operation abandons the operation; the stack is empty after release.
- A token transfers on a clock edge with in_valid && in_ready.
- in_ready = (state==IDLE). It is 0 in EXEC, WB and ERR.
- clear has priority over everything except reset. On clear: sp=0, err=0, err_code=0, state IDLE, done=0. Any token offered in the same cycle is dropped.
- States: IDLE, EXEC, WB, ERR.
- IDLE, number token:
  - depth==DEPTH: err=1, err_code=2, go to ERR, stack unchanged.
  - Otherwise stack[sp]<=in_data, sp<=sp+1, stay IDLE. Single-cycle push; back-to-back pushes allowed.
- IDLE, operator token, checked in this order:
  1. depth<2: err_code=1, go to ERR.
  2. in_op is not one of the four codes: err_code=3, go to ERR.
  3. in_op==`AC_DI and stack[sp-1]==0: err_code=3, go to ERR.
  4. Otherwise: alu_a<=stack[sp-2], alu_b<=stack[sp-1], alu_cmd<=in_op, go to EXEC.
  - All error paths leave the stack unchanged.
- EXEC: one full cycle for the ALU path to settle. At the end of the cycle, result register<=alu_c, go to WB.
- WB: stack[sp-2]<=result, sp<=sp-1, done=1 for this cycle, go to IDLE.
- Timing for an operator accepted at edge t0:
  - EXEC occupies cycle t0..t1.
  - WB occupies t1..t2; done is high in that cycle.
  - top/depth update at t2; in_ready is high again after t2.
- ERR: hold all state. in_ready=0. Only clear or reset exits.
- alu_a, alu_b and alu_cmd hold their last values outside operator setup.
- Arithmetic: the result is the ALU's N-bit signed result, with no overflow detection.
  - Add/sub/mul wrap modulo 2^N.
  - Divide truncates toward zero; MIN/-1 yields MIN.
- Net depth change: number +1, operator -1.

Test Plan:
- Push 7, push 5, op `AC_SB → during EXEC alu_a=7, alu_b=5. done pulses 2 cycles after accept. Then top=2, depth=1, in_ready=1.
- Push -6, push 4, op `AC_MU → top=16'hFFE8 (-24), depth=1. Then push -32768, push -1, op `AC_DI → top=16'h8000, depth=2.
- Push 9, push 0, op `AC_DI → err=1, err_code=3, depth=2, top=0, in_ready=0, no done. Then pulse clear → depth=0, err=0, in_ready=1.
- Push 1..8 (DEPTH=8), then push 9 → err_code=2, depth=8, top=8. Separately, after clear: push 1, op `AC_AD → err_code=1, depth=1.
- Push 3, push 4, op `AC_AD; drive rst_n low during EXEC → immediately alu_a=alu_b=0, depth=0, done never pulses. After release, in_ready=1 and push 5 → top=5.
- clear asserted in the same cycle as a valid number token → token dropped, depth=0.
